// File: rtl/iq_sweep_ctrl_if.sv
// Result handshake between the sweep controller and the downstream consumer.
// The controller drives each averaged I/Q point, and the consumer accepts it with res_ready.
interface iq_sweep_ctrl_if #(
    parameter int OUTPUT_WIDTH = 12
);
    logic                    res_valid;
    logic                    res_ready;
    logic [OUTPUT_WIDTH-1:0] res_I;
    logic [OUTPUT_WIDTH-1:0] res_Q;
    logic [15:0]             res_idx;

    modport master (
        output res_valid, res_I, res_Q, res_idx,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_I, res_Q, res_idx,
        output res_ready
    );
endinterface

// File: rtl/iq_sweep_ctrl.sv
// Steps the mixer LO across a programmed sweep and holds the mixer in reset while retuning.
// It discards CIC settling samples, averages 2^AVG_LOG2 I/Q samples per point and hands each result downstream.
module iq_sweep_ctrl #(
    parameter int PHASE_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 12,
    parameter int AVG_LOG2     = 3,
    parameter int RST_CYCLES   = 4
) (
    input  logic                           clk,
    input  logic                           RST_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [PHASE_WIDTH-1:0]         f_start,
    input  logic [PHASE_WIDTH-1:0]         f_step,
    input  logic [15:0]                    n_points,
    input  logic [15:0]                    factor_in,
    input  logic [7:0]                     settle_cnt,
    output logic [PHASE_WIDTH-1:0]         Fre_word,
    output logic [15:0]                    FACTOR,
    output logic                           mixer_rst,
    input  logic                           mix_ce,
    input  logic signed [OUTPUT_WIDTH-1:0] I_in,
    input  logic signed [OUTPUT_WIDTH-1:0] Q_in,
    iq_sweep_ctrl_if.master                res,
    output logic                           busy,
    output logic                           done
);

    localparam int ACC_W = OUTPUT_WIDTH + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [SMP_W-1:0] LAST_SAMPLE = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RETUNE,
        S_SETTLE,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t state_q, state_d;
    logic   done_d;

    logic [PHASE_WIDTH-1:0]  step_q;
    logic [15:0]             npts_q;
    logic [15:0]             idx_q;
    logic [7:0]              settle_q;
    logic [7:0]              settle_seen_q;
    logic [RST_W-1:0]        rst_cnt_q;
    logic [SMP_W-1:0]        smp_cnt_q;
    logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;

    // Size casts keep the signedness of I_in/Q_in, so these sign-extend into the accumulator.
    assign sum_i = acc_i_q + ACC_W'(I_in);
    assign sum_q = acc_q_q + ACC_W'(Q_in);

    // NOTE: every variable written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_points == 16'd0) done_d  = 1'b1;
                    else                   state_d = S_RETUNE;
                end
            end
            S_RETUNE: begin
                if (rst_cnt_q == RST_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == 8'd0 || (mix_ce && settle_seen_q == settle_q - 8'd1))
                    state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (mix_ce && smp_cnt_q == LAST_SAMPLE) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (res.res_ready) begin
                    if (idx_q == npts_q - 16'd1) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RETUNE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: status outputs are decoded from state_d, so they are registered yet line up with the new state.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            Fre_word      <= '0;
            FACTOR        <= '0;
            mixer_rst     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            res.res_valid <= 1'b0;
            res.res_I     <= '0;
            res.res_Q     <= '0;
            res.res_idx   <= '0;
            step_q        <= '0;
            npts_q        <= '0;
            idx_q         <= '0;
            settle_q      <= '0;
            settle_seen_q <= '0;
            rst_cnt_q     <= '0;
            smp_cnt_q     <= '0;
            acc_i_q       <= '0;
            acc_q_q       <= '0;
        end else begin
            done          <= done_d;
            busy          <= (state_d != S_IDLE);
            mixer_rst     <= (state_d == S_IDLE) || (state_d == S_RETUNE);
            res.res_valid <= (state_d == S_OUTPUT);

            rst_cnt_q <= (state_q == S_RETUNE && state_d == S_RETUNE) ? rst_cnt_q + RST_W'(1) : '0;

            if (state_q != S_SETTLE) settle_seen_q <= '0;
            else if (mix_ce)         settle_seen_q <= settle_seen_q + 8'd1;

            // Accumulators sit at zero outside CAPTURE, so they are clear on every entry.
            if (state_q != S_CAPTURE) begin
                acc_i_q   <= '0;
                acc_q_q   <= '0;
                smp_cnt_q <= '0;
            end else if (mix_ce) begin
                acc_i_q   <= sum_i;
                acc_q_q   <= sum_q;
                smp_cnt_q <= smp_cnt_q + SMP_W'(1);
            end

            if (state_q == S_CAPTURE && state_d == S_OUTPUT) begin
                res.res_I   <= OUTPUT_WIDTH'(sum_i >>> AVG_LOG2);
                res.res_Q   <= OUTPUT_WIDTH'(sum_q >>> AVG_LOG2);
                res.res_idx <= idx_q;
            end

            if (state_q == S_IDLE && state_d == S_RETUNE) begin
                step_q   <= f_step;
                npts_q   <= n_points;
                settle_q <= settle_cnt;
                idx_q    <= '0;
                Fre_word <= f_start;
                FACTOR   <= factor_in;
            end

            if (state_q == S_OUTPUT && state_d == S_RETUNE) begin
                idx_q    <= idx_q + 16'd1;
                Fre_word <= Fre_word + step_q;
            end
        end
    end

endmodule

// File: doc/iq_sweep_ctrl.md
# iq_sweep_ctrl

Sequencer for the IQ demodulation chain: steps the mixer LO frequency word across a programmed sweep, holds the mixer/CIC in reset while retuning, and discards CIC output samples until the filter has settled. It then averages a block of decimated I/Q samples per point and hands each result to downstream logic over a valid/ready handshake. It sits between the control register block and the IQ mixer, driving the mixer's `Fre_word`, `FACTOR` and reset and consuming its decimated `clk_out`/`I_OUT`/`Q_OUT`.

## Interface
- `PHASE_WIDTH`, 32, LO frequency word width.
- `OUTPUT_WIDTH`, 12, mixer I/Q sample width (signed).
- `AVG_LOG2`, 3, log2 of samples averaged per point (0..8).
- `RST_CYCLES`, 4, mixer reset pulse length in clk cycles (>=1).

- `clk` in 1: system clock, all logic rising-edge.
- `RST_n` in 1: asynchronous active-low reset.
- `start` in 1: begin sweep; honoured only in IDLE.
- `abort` in 1: terminate sweep, synchronous.
- `f_start` in PHASE_WIDTH: first frequency word.
- `f_step` in PHASE_WIDTH: per-point increment, unsigned, modulo 2^PHASE_WIDTH.
- `n_points` in 16: points in sweep.
- `factor_in` in 16: CIC decimation factor.
- `settle_cnt` in 8: decimated samples discarded after each retune.
- `Fre_word` out PHASE_WIDTH: to mixer.
- `FACTOR` out 16: to mixer.
- `mixer_rst` out 1: active-high reset to mixer.
- `mix_ce` in 1: mixer decimated-sample strobe (`clk_out`), one clk wide.
- `I_in`, `Q_in` in OUTPUT_WIDTH each: mixer outputs, valid when `mix_ce`=1.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_I`, `res_Q` out OUTPUT_WIDTH each: averaged result.
- `res_idx` out 16: point index of result.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at sweep completion.

## Operation
- States: IDLE, RETUNE, SETTLE, CAPTURE, OUTPUT.
- IDLE: `mixer_rst`=1, `busy`=0. On `start`: if `n_points`=0, pulse `done` next cycle and stay IDLE; else latch `f_start`, `f_step`, `n_points`, `factor_in`, `settle_cnt`, set idx=0, `Fre_word`=`f_start`, `FACTOR`=`factor_in`, go RETUNE. Inputs are not re-sampled mid-sweep.
- RETUNE: `mixer_rst`=1 for exactly RST_CYCLES cycles, then SETTLE. `mix_ce` ignored.
- SETTLE: `mixer_rst`=0. Count `mix_ce` pulses. After latched `settle_cnt` pulses go CAPTURE; if `settle_cnt`=0, go CAPTURE on the cycle after entry.
- CAPTURE: on each `mix_ce`, sign-extend `I_in`/`Q_in` and add to accumulators of width OUTPUT_WIDTH+AVG_LOG2. The accumulators clear on entry. After 2^AVG_LOG2 samples, register `res_I`/`res_Q` as accumulator arithmetic-shifted right by AVG_LOG2 (truncate toward -inf) and set `res_idx`=idx. Then go OUTPUT.
- OUTPUT: `res_valid`=1; `res_I`/`res_Q`/`res_idx` stable until handshake. `mix_ce` ignored. On `res_valid`&`res_ready`: if idx=n_points-1, pulse `done`, go IDLE; else idx+1, `Fre_word`+=`f_step` (wraps), go RETUNE.
- `abort` has priority over all transitions: next state IDLE, `res_valid` cleared, `mixer_rst`=1, no `done` pulse. Outputs `Fre_word`/`FACTOR` hold their last values.
- `start` while busy is ignored.

## Timing
- Reset values: `Fre_word`=0, `FACTOR`=0, `mixer_rst`=1, `res_valid`=0, `res_I`=`res_Q`=0, `res_idx`=0, `busy`=0, `done`=0. State IDLE.
- All outputs are registered.
- `start` sampled at edge T: `busy`=1, `Fre_word`/`FACTOR` valid, and `mixer_rst`=1 from T+1. `mixer_rst` falls at T+1+RST_CYCLES.
- A `mix_ce` in the same cycle as SETTLE→CAPTURE belongs to SETTLE; it is not accumulated.
- `res_valid` rises the cycle after the last captured `mix_ce`.
- Handshake at edge H: `res_valid`=0 at H+1; next retune `mixer_rst`=1 at H+1. `done` and `busy`=0 also at H+1 for the last point.
- `abort` at edge A: IDLE state outputs at A+1.

## Test plan
- Reset asserted mid-CAPTURE -> all outputs return to reset values immediately (async), IDLE after release.
- f_start=0x1000, f_step=0x100, n_points=3, settle=2, AVG_LOG2=3, constant I_in=100, Q_in=-50, res_ready=1 -> results idx 0,1,2 with I=100, Q=-50, `Fre_word` 0x1000/0x1100/0x1200, RETUNE `mixer_rst` pulse exactly 4 cycles, `done` single pulse.
- I_in alternating 3,-4 over 8 samples -> `res_I`=-1 (floor of -0.5); f_start=0xFFFFFF80, f_step=0x100 -> second `Fre_word`=0x00000080.
- `res_ready` low 10 cycles in OUTPUT with `mix_ce` pulsing -> result stable, `res_valid` held, no accumulation.
- n_points=0 start -> `done` pulse at T+1, `busy` stays 0, `mixer_rst` stays 1; `start` during busy -> no effect.
- settle_cnt=0 with `abort` in SETTLE of point 1 -> IDLE next cycle, `res_valid`=0, no `done`; new `start` runs a clean sweep.
